norm_collector: RTL and testbench
=================================

Name: norm_collector

Overview:
- Receiving end of the normalizer output stream.
- Captures the two-lane normalized word stream (psum_norm_1 / psum_norm_2, qualified by norm_valid), one word per lane per beat.
- Reassembles COL words per lane into full output rows and buffers complete rows in a small FIFO.
- Downstream logic (output SRAM writer / host readout) drains rows with a valid/ready handshake.

Parameters:
- BW_PSUM, 11, width of one normalized word (matches the normalizer W_OUT).
- COL, 8, words per row per lane (per-core column count).
- DEPTH, 4, FIFO depth in row pairs; power of two, at least 2.

Ports:
- clk  input  1  clock.
- reset  input  1  reset. One clock; reset is synchronous and active-high.
- norm_valid  input  1  beat qualifier for both lanes.
- psum_norm_1  input  BW_PSUM  lane-1 (core1) normalized word.
- psum_norm_2  input  BW_PSUM  lane-2 (core2) normalized word.
- flush  input  1  close the partial row currently being assembled.
- out_valid  output  1  FIFO head row is valid.
- out_ready  input  1  consumer accepts the head row.
- out_row_1  output  BW_PSUM*COL  lane-1 head row; word k at bits [k*BW_PSUM +: BW_PSUM].
- out_row_2  output  BW_PSUM*COL  lane-2 head row, same packing.
- out_words  output  $clog2(COL+1)  number of valid words in the head row (COL unless the row was flushed).
- fill_level  output  $clog2(DEPTH+1)  rows held in the FIFO.
- overflow  output  1  sticky: a completed row was dropped.

Behaviour:
- Reset (sync, active-high): beat counter = 0; assembly registers = 0; FIFO empty. Output values during reset: out_valid=0, fill_level=0, overflow=0, out_row_1/out_row_2=0, out_words=0.
- Assembly
  - On each norm_valid cycle, both lane words are written to index beat_cnt of their assembly registers. The first beat after a row closes lands at index 0 (LSBs).
  - beat_cnt increments 0..COL-1.
  - On the beat where beat_cnt==COL-1: the completed row pair (including that beat's words) is pushed with out_words=COL, and beat_cnt wraps to 0.
- Flush
  - flush with beat_cnt>0 and no norm_valid: push the partial row with out_words=beat_cnt; unwritten words are 0. beat_cnt becomes 0 and the assembly registers clear.
  - flush together with norm_valid: the beat is captured first, then the row is closed with out_words=beat_cnt+1. If that beat is also the COL-th word, this is a normal full-row push; exactly one push, never two.
  - flush with beat_cnt==0 and no norm_valid: no effect.
- FIFO
  - Show-ahead: out_row_1, out_row_2 and out_words always reflect the head entry while out_valid=1.
  - Pop occurs when out_valid and out_ready.
  - Head outputs are registered. A push into an empty FIFO at cycle t gives out_valid=1 at t+1. Never combinational from the inputs.
  - Push when full and no pop in the same cycle: the row is dropped, overflow is set (sticky until reset), FIFO contents are unchanged, and assembly continues with beat_cnt=0.
  - Push when full with a pop in the same cycle: accepted, fill_level unchanged, no overflow.
  - Push and pop when fill_level==1: the new row becomes head at t+1 and out_valid stays 1.
  - out_ready while out_valid=0 is ignored.
  - fill_level updates on the cycle after a push/pop; read and write pointers wrap modulo DEPTH.
- Handshake rule: while out_valid=1 and out_ready=0, the head outputs are stable.
- Data are treated as raw bits (no sign handling, no arithmetic).
- Reset mid-row or mid-drain discards everything, including rows held in the FIFO.

Test Plan:
- Full-row capture:
  - Stimulus: COL=8, 8 consecutive beats, lane1=1..8, lane2=0x101..0x108.
  - Response: out_valid rises 1 cycle after beat 8; out_row_1 word0=1, word7=8; out_words=8; fill_level=1.
- Flush partial row:
  - Stimulus: 3 beats (5,6,7), then flush alone.
  - Response: head row words0..2 = 5,6,7, words3..7 = 0; out_words=3. The next beat lands at index 0.
- Flush coinciding with beat:
  - Stimulus: flush on the 8th beat.
  - Response: exactly one push, out_words=8, fill_level=1.
- Overflow:
  - Stimulus: out_ready=0, DEPTH=4, push 5 full rows.
  - Response: fill_level=4; overflow=1 after the 5th row completes; head still equals row 1. Rows 1-4 then drain in order with rows unchanged.
- Full push with simultaneous pop:
  - Stimulus: FIFO full; out_ready=1 on the same cycle as a row completes.
  - Response: fill_level stays 4, overflow stays 0, row order preserved.
- Back-pressure and reset:
  - Stimulus: hold out_ready=0 for 10 cycles, then assert reset mid-row for 1 cycle.
  - Response: head outputs are stable while stalled. After reset, out_valid=0, fill_level=0, overflow=0, and the next beat lands at index 0.

Source files
------------

// File: rtl/norm_collector.sv
// Packs two-lane normalized word beats into COL-word rows and queues them in a show-ahead row FIFO.
// A closed row reaches the registered head one cycle later; a full FIFO without a pop drops the row and sets sticky overflow.
module norm_collector #(
  parameter int BW_PSUM = 11,
  parameter int COL     = 8,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         norm_valid,
  input  logic [BW_PSUM-1:0]           psum_norm_1,
  input  logic [BW_PSUM-1:0]           psum_norm_2,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BW_PSUM*COL-1:0]       out_row_1,
  output logic [BW_PSUM*COL-1:0]       out_row_2,
  output logic [$clog2(COL+1)-1:0]     out_words,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         overflow
);

  localparam int ROWW = BW_PSUM * COL;
  localparam int WW   = $clog2(COL + 1);
  localparam int BCW  = (COL > 1) ? $clog2(COL) : 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW   = $clog2(DEPTH + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(COL - 1);
  localparam logic [FW-1:0]  FULL_LVL  = FW'(DEPTH);

  typedef struct packed {
    logic [WW-1:0]   words;
    logic [ROWW-1:0] row_2;
    logic [ROWW-1:0] row_1;
  } entry_t;

  logic [BCW-1:0]  beat_cnt;
  logic [ROWW-1:0] asm_1, asm_2;
  logic [ROWW-1:0] cap_1, cap_2;
  entry_t          mem [DEPTH];
  entry_t          push_entry;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [FW-1:0]   count;
  logic            close_row, full, pop, push_ok;

  // Row as it stands after this cycle's beat; unwritten slots stay zero.
  always_comb begin
    cap_1 = asm_1;
    cap_2 = asm_2;
    if (norm_valid) begin
      for (int k = 0; k < COL; k++) begin
        if (BCW'(k) == beat_cnt) begin
          cap_1[k*BW_PSUM +: BW_PSUM] = psum_norm_1;
          cap_2[k*BW_PSUM +: BW_PSUM] = psum_norm_2;
        end
      end
    end
  end

  always_comb begin
    close_row = norm_valid ? ((beat_cnt == LAST_BEAT) || flush)
                           : (flush && (beat_cnt != '0));
    push_entry.row_1 = cap_1;
    push_entry.row_2 = cap_2;
    push_entry.words = norm_valid ? (WW'(beat_cnt) + WW'(1)) : WW'(beat_cnt);
    full    = (count == FULL_LVL);
    pop     = out_valid && out_ready;
    push_ok = close_row && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      asm_1    <= '0;
      asm_2    <= '0;
    end else if (close_row) begin
      beat_cnt <= '0;
      asm_1    <= '0;
      asm_2    <= '0;
    end else if (norm_valid) begin
      beat_cnt <= beat_cnt + BCW'(1);
      asm_1    <= cap_1;
      asm_2    <= cap_2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + FW'(1);
      else if (!push_ok && pop) count <= count - FW'(1);
      if (close_row && !push_ok) overflow <= 1'b1;
    end
  end

  // When full with a pop, wr_ptr equals rd_ptr: the slot being overwritten is the one leaving.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    out_valid  = (count != '0);
    fill_level = count;
    out_row_1  = out_valid ? mem[rd_ptr].row_1 : '0;
    out_row_2  = out_valid ? mem[rd_ptr].row_2 : '0;
    out_words  = out_valid ? mem[rd_ptr].words : '0;
  end

endmodule

// File: tb/tb_norm_collector.sv
// Bench for norm_collector: queue-based row model checked every cycle, plus directed literal checks.
module tb_norm_collector;

  localparam int BW    = 11;
  localparam int COL   = 8;
  localparam int DEPTH = 4;
  localparam int ROWW  = BW * COL;
  localparam int WW    = $clog2(COL + 1);
  localparam int FW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            norm_valid = 1'b0;
  logic [BW-1:0]   psum_norm_1 = '0;
  logic [BW-1:0]   psum_norm_2 = '0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [ROWW-1:0] out_row_1, out_row_2;
  logic [WW-1:0]   out_words;
  logic [FW-1:0]   fill_level;
  logic            overflow;

  always #5 clk = ~clk;

  norm_collector #(.BW_PSUM(BW), .COL(COL), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .norm_valid(norm_valid),
    .psum_norm_1(psum_norm_1), .psum_norm_2(psum_norm_2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row_1(out_row_1), .out_row_2(out_row_2), .out_words(out_words),
    .fill_level(fill_level), .overflow(overflow)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] w(input logic [ROWW-1:0] r, input int k);
    return r[k*BW +: BW];
  endfunction

  // Reference model: a list of pending words and a queue of complete rows.
  typedef struct {
    logic [ROWW-1:0] r1;
    logic [ROWW-1:0] r2;
    int              words;
  } row_t;

  row_t          mq[$];
  logic [BW-1:0] p1[COL];
  logic [BW-1:0] p2[COL];
  int            pn = 0;
  bit            m_ovf = 0;

  always @(posedge clk) begin : model
    bit   popped;
    row_t nr;
    if (reset) begin
      mq.delete();
      pn    = 0;
      m_ovf = 0;
    end else begin
      popped = (mq.size() > 0) && out_ready;
      if (popped) void'(mq.pop_front());
      if (norm_valid) begin
        p1[pn] = psum_norm_1;
        p2[pn] = psum_norm_2;
        pn++;
      end
      if (pn == COL || (flush && pn > 0)) begin
        nr.r1 = '0;
        nr.r2 = '0;
        for (int k = 0; k < pn; k++) begin
          nr.r1[k*BW +: BW] = p1[k];
          nr.r2[k*BW +: BW] = p2[k];
        end
        nr.words = pn;
        if (mq.size() < DEPTH) mq.push_back(nr);
        else m_ovf = 1;
        pn = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("fill_level", fill_level, mq.size());
      chk("overflow", overflow, m_ovf);
      if (mq.size() > 0) begin
        chk("out_row_1", out_row_1, mq[0].r1);
        chk("out_row_2", out_row_2, mq[0].r2);
        chk("out_words", out_words, mq[0].words);
      end
    end
  end

  task automatic drive(input bit nv, input logic [BW-1:0] d1, input logic [BW-1:0] d2,
                       input bit fl, input bit rdy, input bit rst);
    norm_valid  = nv;
    psum_norm_1 = d1;
    psum_norm_2 = d2;
    flush       = fl;
    out_ready   = rdy;
    reset       = rst;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    drive(0, '0, '0, 0, rdy, 0);
  endtask

  task automatic full_row(input int base, input bit rdy);
    for (int k = 0; k < COL; k++)
      drive(1, BW'(base + k), BW'(256 + base + k), 0, rdy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int mode;
    @(negedge clk);
    drive(0, '0, '0, 0, 0, 1);
    drive(0, '0, '0, 0, 0, 1);
    chk_en = 1;
    chk("rst out_valid", out_valid, 0);
    chk("rst fill_level", fill_level, 0);
    chk("rst overflow", overflow, 0);
    chk("rst out_words", out_words, 0);
    chk("rst out_row_1", out_row_1, 0);
    chk("rst out_row_2", out_row_2, 0);

    // Full-row capture
    for (int k = 1; k <= COL; k++) drive(1, BW'(k), BW'(256 + k), 0, 0, 0);
    chk("full valid", out_valid, 1);
    chk("full w0", w(out_row_1, 0), 1);
    chk("full w7", w(out_row_1, 7), 8);
    chk("full lane2 w0", w(out_row_2, 0), 'h101);
    chk("full words", out_words, 8);
    chk("full fill", fill_level, 1);
    idle(1);
    chk("full drained", out_valid, 0);

    // Flush of a partial row, then the next beat lands at index 0
    drive(1, 11'd5, 11'h205, 0, 0, 0);
    drive(1, 11'd6, 11'h206, 0, 0, 0);
    drive(1, 11'd7, 11'h207, 0, 0, 0);
    drive(0, '0, '0, 1, 0, 0);
    chk("flush row", out_row_1, {55'b0, 11'd7, 11'd6, 11'd5});
    chk("flush words", out_words, 3);
    drive(1, 11'd9, 11'h109, 0, 1, 0);
    drive(0, '0, '0, 1, 0, 0);
    chk("flush next row", out_row_1, {77'b0, 11'd9});
    chk("flush next words", out_words, 1);
    idle(1);

    // Flush coinciding with the COL-th beat
    for (int k = 0; k < COL - 1; k++) drive(1, BW'(32 + k), BW'(64 + k), 0, 0, 0);
    drive(1, 11'h27, 11'h47, 1, 0, 0);
    chk("flushfull fill", fill_level, 1);
    chk("flushfull words", out_words, 8);
    idle(0);
    chk("flushfull single push", fill_level, 1);
    idle(1);

    // Overflow with a stalled consumer
    for (int r = 1; r <= 5; r++) begin
      full_row(r * 16, 0);
      if (r == 4) begin
        chk("ovf fill4", fill_level, 4);
        chk("ovf not yet", overflow, 0);
      end
    end
    chk("ovf set", overflow, 1);
    chk("ovf fill", fill_level, 4);
    chk("ovf head", w(out_row_1, 0), 16);
    for (int r = 1; r <= 4; r++) begin
      chk("ovf drain w0", w(out_row_1, 0), r * 16);
      chk("ovf drain w7", w(out_row_1, 7), r * 16 + 7);
      idle(1);
    end
    chk("ovf empty", out_valid, 0);
    chk("ovf sticky", overflow, 1);
    drive(0, '0, '0, 0, 0, 1);

    // Full FIFO with a pop on the completing beat
    for (int r = 1; r <= 4; r++) full_row(r * 16, 0);
    for (int k = 0; k < COL - 1; k++) drive(1, BW'(80 + k), BW'(336 + k), 0, 0, 0);
    drive(1, BW'(87), BW'(343), 0, 1, 0);
    chk("fullpop fill", fill_level, 4);
    chk("fullpop ovf", overflow, 0);
    for (int r = 2; r <= 5; r++) begin
      chk("fullpop order", w(out_row_1, 0), r * 16);
      idle(1);
    end

    // Back-pressure stability, then reset mid-row
    full_row(48, 0);
    for (int k = 0; k < 3; k++) drive(1, BW'(96 + k), BW'(96 + k), 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      idle(0);
      chk("stall w3", w(out_row_1, 3), 51);
      chk("stall words", out_words, 8);
    end
    drive(1, 11'h77, 11'h77, 0, 0, 1);
    chk("mid rst valid", out_valid, 0);
    chk("mid rst fill", fill_level, 0);
    chk("mid rst ovf", overflow, 0);
    full_row(64, 0);
    chk("post rst w0", w(out_row_1, 0), 64);
    chk("post rst w7", w(out_row_1, 7), 71);
    idle(1);

    // Randomized traffic with varying consumer pressure
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      bit nv, fl, rdy, rst;
      if (c % 64 == 0) mode = int'($urandom_range(0, 2));
      nv  = ($urandom_range(0, 99) < 60);
      fl  = ($urandom_range(0, 99) < 12);
      rdy = (mode == 0) ? ($urandom_range(0, 99) < 90)
          : (mode == 1) ? ($urandom_range(0, 99) < 20) : 1'b0;
      rst = ($urandom_range(0, 499) == 0);
      drive(nv, BW'($urandom), BW'($urandom), fl, rdy, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
